// File: rtl/res_net_ctrl_if.sv
// Handshake and data bundle between the resonator sequencing controller and its environment.
// The slave modport is the controller's view; master is the upstream/downstream/network side.
interface res_net_ctrl_if #(
    parameter int VECTOR_LEN = 1024,
    parameter int ITER_W     = 7
);
    logic                  i_scene_valid;
    logic                  o_scene_ready;
    logic [VECTOR_LEN-1:0] i_scene;
    logic [VECTOR_LEN-1:0] o_scene;
    logic                  o_init;

    logic                  i_color_converged;
    logic                  i_shape_converged;
    logic                  i_position_converged;
    logic [VECTOR_LEN-1:0] i_color_prediction;
    logic [VECTOR_LEN-1:0] i_shape_prediction;
    logic [VECTOR_LEN-1:0] i_position_prediction;

    logic                  o_result_valid;
    logic                  i_result_ready;
    logic [VECTOR_LEN-1:0] o_color;
    logic [VECTOR_LEN-1:0] o_shape;
    logic [VECTOR_LEN-1:0] o_position;
    logic                  o_timeout;
    logic [ITER_W-1:0]     o_iter_count;
    logic                  o_busy;

    modport slave (
        input  i_scene_valid, i_scene,
        input  i_color_converged, i_shape_converged, i_position_converged,
        input  i_color_prediction, i_shape_prediction, i_position_prediction,
        input  i_result_ready,
        output o_scene_ready, o_scene, o_init,
        output o_result_valid, o_color, o_shape, o_position,
        output o_timeout, o_iter_count, o_busy
    );

    modport master (
        output i_scene_valid, i_scene,
        output i_color_converged, i_shape_converged, i_position_converged,
        output i_color_prediction, i_shape_prediction, i_position_prediction,
        output i_result_ready,
        input  o_scene_ready, o_scene, o_init,
        input  o_result_valid, o_color, o_shape, o_position,
        input  o_timeout, o_iter_count, o_busy
    );
endinterface

// File: rtl/res_net_ctrl.sv
// Sequences one scene through the resonator network: accept, init pulse, iterate, capture result.
// Latency: at least STABLE_CYCLES+2 cycles from scene accept to result valid; one scene in flight.
// Backpressure: scene ready only in IDLE; result held frozen in DONE until downstream ready.
module res_net_ctrl #(
    parameter int VECTOR_LEN    = 1024,
    parameter int MAX_ITERS     = 100,
    parameter int STABLE_CYCLES = 2,
    parameter int ITER_W        = $clog2(MAX_ITERS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    res_net_ctrl_if.slave bus
);
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);

    localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITERS - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITERS);
    localparam logic [STAB_W-1:0] STAB_TGT  = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W:0]   STAB_ONE  = (STAB_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, INIT, ITER, DONE} state_t;

    typedef struct packed {
        logic [VECTOR_LEN-1:0] color;
        logic [VECTOR_LEN-1:0] shape;
        logic [VECTOR_LEN-1:0] position;
    } pred_t;

    state_t                state_q, state_d;
    logic [VECTOR_LEN-1:0] scene_q, scene_d;
    logic [ITER_W-1:0]     iter_q, iter_d;
    logic [ITER_W-1:0]     iter_cnt_q, iter_cnt_d;
    logic [STAB_W-1:0]     stable_q, stable_d;
    logic                  timeout_q, timeout_d;
    pred_t                 res_q, res_d;
    pred_t                 pred_in;

    logic                  all_conv;
    logic [STAB_W:0]       stable_inc;
    logic                  stable_hit;

    assign pred_in    = {bus.i_color_prediction, bus.i_shape_prediction, bus.i_position_prediction};
    assign all_conv   = bus.i_color_converged & bus.i_shape_converged & bus.i_position_converged;
    assign stable_inc = {1'b0, stable_q} + STAB_ONE;
    assign stable_hit = all_conv && (stable_inc >= {1'b0, STAB_TGT});

    always_comb begin
        state_d    = state_q;
        scene_d    = scene_q;
        iter_d     = iter_q;
        iter_cnt_d = iter_cnt_q;
        stable_d   = stable_q;
        timeout_d  = timeout_q;
        res_d      = res_q;

        case (state_q)
            IDLE: begin
                if (bus.i_scene_valid) begin
                    scene_d  = bus.i_scene;
                    iter_d   = '0;
                    stable_d = '0;
                    state_d  = INIT;
                end
            end
            INIT: begin
                state_d = ITER;
            end
            ITER: begin
                if (!all_conv) begin
                    stable_d = '0;
                end else if (stable_hit) begin
                    stable_d = STAB_TGT;
                end else begin
                    stable_d = stable_inc[STAB_W-1:0];
                end

                // Convergence wins over the iteration limit when both land on the same cycle.
                if (stable_hit) begin
                    res_d      = pred_in;
                    timeout_d  = 1'b0;
                    iter_cnt_d = iter_q + ITER_ONE;
                    state_d    = DONE;
                end else if (iter_q == ITER_LAST) begin
                    res_d      = pred_in;
                    timeout_d  = 1'b1;
                    iter_cnt_d = ITER_MAX;
                    state_d    = DONE;
                end else begin
                    iter_d = iter_q + ITER_ONE;
                end
            end
            DONE: begin
                if (bus.i_result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            scene_q    <= '0;
            iter_q     <= '0;
            iter_cnt_q <= '0;
            stable_q   <= '0;
            timeout_q  <= 1'b0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            scene_q    <= scene_d;
            iter_q     <= iter_d;
            iter_cnt_q <= iter_cnt_d;
            stable_q   <= stable_d;
            timeout_q  <= timeout_d;
            res_q      <= res_d;
        end
    end

    assign bus.o_scene_ready  = (state_q == IDLE);
    assign bus.o_init         = (state_q == INIT);
    assign bus.o_result_valid = (state_q == DONE);
    assign bus.o_busy         = (state_q == INIT) || (state_q == ITER);
    assign bus.o_scene        = scene_q;
    assign bus.o_color        = res_q.color;
    assign bus.o_shape        = res_q.shape;
    assign bus.o_position     = res_q.position;
    assign bus.o_timeout      = timeout_q;
    assign bus.o_iter_count   = iter_cnt_q;
endmodule

// File: tb/tb_res_net_ctrl.sv
// Directed bench for res_net_ctrl with VECTOR_LEN=16, MAX_ITERS=8, STABLE_CYCLES=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_res_net_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [15:0] exp_scene;

    res_net_ctrl_if #(.VECTOR_LEN(16), .ITER_W(4)) bus ();

    res_net_ctrl #(
        .VECTOR_LEN(16),
        .MAX_ITERS(8),
        .STABLE_CYCLES(2),
        .ITER_W(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_conv(input logic c, input logic s, input logic p);
        bus.i_color_converged    = c;
        bus.i_shape_converged    = s;
        bus.i_position_converged = p;
    endtask

    // Accept a scene from IDLE and step through INIT; returns at the first ITER negedge.
    task automatic start_scene(input logic [15:0] scene, input logic init_conv);
        bus.i_scene       = scene;
        bus.i_scene_valid = 1'b1;
        check("idle_ready", bus.o_scene_ready, 1'b1);
        check("idle_busy", bus.o_busy, 1'b0);
        tick();
        bus.i_scene_valid = 1'b0;
        exp_scene         = scene;
        set_conv(init_conv, init_conv, init_conv);
        check("init_pulse", bus.o_init, 1'b1);
        check("init_busy", bus.o_busy, 1'b1);
        check("init_ready", bus.o_scene_ready, 1'b0);
        check("init_scene", bus.o_scene, scene);
        check("init_rv", bus.o_result_valid, 1'b0);
        tick();
    endtask

    task automatic iter_cyc(input logic c, input logic s, input logic p,
                            input logic [15:0] pc, input logic [15:0] ps, input logic [15:0] pp);
        check("iter_init", bus.o_init, 1'b0);
        check("iter_busy", bus.o_busy, 1'b1);
        check("iter_rv", bus.o_result_valid, 1'b0);
        check("iter_scene", bus.o_scene, exp_scene);
        set_conv(c, s, p);
        bus.i_color_prediction    = pc;
        bus.i_shape_prediction    = ps;
        bus.i_position_prediction = pp;
        tick();
    endtask

    task automatic check_result(input string tag, input logic to, input logic [3:0] cnt,
                                input logic [15:0] c, input logic [15:0] s, input logic [15:0] p);
        check({tag, "_rv"}, bus.o_result_valid, 1'b1);
        check({tag, "_busy"}, bus.o_busy, 1'b0);
        check({tag, "_init"}, bus.o_init, 1'b0);
        check({tag, "_ready"}, bus.o_scene_ready, 1'b0);
        check({tag, "_timeout"}, bus.o_timeout, to);
        check({tag, "_count"}, bus.o_iter_count, cnt);
        check({tag, "_color"}, bus.o_color, c);
        check({tag, "_shape"}, bus.o_shape, s);
        check({tag, "_pos"}, bus.o_position, p);
        check({tag, "_scene"}, bus.o_scene, exp_scene);
    endtask

    task automatic ack_result(input logic [15:0] c);
        bus.i_result_ready = 1'b1;
        tick();
        bus.i_result_ready = 1'b0;
        check("ack_rv", bus.o_result_valid, 1'b0);
        check("ack_ready", bus.o_scene_ready, 1'b1);
        check("ack_retain", bus.o_color, c);
    endtask

    initial begin
        logic [15:0] k16;
        checks = 0;
        errors = 0;
        exp_scene = 16'h0;
        rst = 1'b1;
        bus.i_scene_valid = 1'b0;
        bus.i_scene = 16'h0;
        bus.i_result_ready = 1'b0;
        set_conv(1'b0, 1'b0, 1'b0);
        bus.i_color_prediction = 16'h0;
        bus.i_shape_prediction = 16'h0;
        bus.i_position_prediction = 16'h0;
        repeat (2) tick();

        check("rst_rv", bus.o_result_valid, 1'b0);
        check("rst_init", bus.o_init, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_scene", bus.o_scene, 16'h0);
        check("rst_color", bus.o_color, 16'h0);
        check("rst_timeout", bus.o_timeout, 1'b0);
        check("rst_count", bus.o_iter_count, 4'd0);
        check("rst_ready", bus.o_scene_ready, 1'b1);
        rst = 1'b0;
        tick();

        // Basic convergence; flags already high during INIT must not count.
        start_scene(16'hA5C3, 1'b1);
        iter_cyc(1, 1, 1, 16'h1111, 16'h2222, 16'h3333);
        iter_cyc(1, 1, 1, 16'h1111, 16'h2222, 16'h3333);
        check_result("conv", 1'b0, 4'd2, 16'h1111, 16'h2222, 16'h3333);
        ack_result(16'h1111);

        // Flicker in cycle 2 restarts the stability run.
        start_scene(16'h0F0F, 1'b0);
        iter_cyc(1, 1, 1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        iter_cyc(1, 0, 1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        iter_cyc(1, 1, 1, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        iter_cyc(1, 1, 1, 16'h4444, 16'h5555, 16'h6666);
        check_result("flick", 1'b0, 4'd4, 16'h4444, 16'h5555, 16'h6666);
        ack_result(16'h4444);

        // Timeout: predictions captured are the cycle-8 values.
        start_scene(16'h3C3C, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            k16 = 16'(k * 257);
            iter_cyc(0, 1, 1, k16, ~k16, k16 ^ 16'hF0F0);
        end
        check_result("tmo", 1'b1, 4'd8, 16'h0808, 16'hF7F7, 16'hF8F8);
        ack_result(16'h0808);

        // Convergence on the last allowed cycle beats timeout.
        start_scene(16'h9669, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            k16 = 16'(k * 257);
            if (k >= 7) iter_cyc(1, 1, 1, k16, ~k16, k16 ^ 16'hF0F0);
            else        iter_cyc(1, 1, 0, k16, ~k16, k16 ^ 16'hF0F0);
        end
        check_result("both", 1'b0, 4'd8, 16'h0808, 16'hF7F7, 16'hF8F8);

        // Backpressure: hold the result while inputs churn and a new scene waits.
        bus.i_scene = 16'hFFFF;
        bus.i_scene_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.i_color_prediction = 16'($urandom);
            bus.i_shape_prediction = 16'($urandom);
            bus.i_position_prediction = 16'($urandom);
            set_conv(1'b1, 1'b1, 1'b1);
            tick();
            check_result("bp", 1'b0, 4'd8, 16'h0808, 16'hF7F7, 16'hF8F8);
        end
        bus.i_result_ready = 1'b1;
        tick();
        bus.i_result_ready = 1'b0;
        check("bp_idle_rv", bus.o_result_valid, 1'b0);
        check("bp_idle_ready", bus.o_scene_ready, 1'b1);
        check("bp_idle_scene", bus.o_scene, 16'h9669);
        tick();
        bus.i_scene_valid = 1'b0;
        exp_scene = 16'hFFFF;
        check("bp_accept_init", bus.o_init, 1'b1);
        check("bp_accept_scene", bus.o_scene, 16'hFFFF);
        set_conv(1'b0, 1'b0, 1'b0);
        tick();
        iter_cyc(1, 1, 1, 16'h7777, 16'h8888, 16'h9999);
        iter_cyc(1, 1, 1, 16'h7777, 16'h8888, 16'h9999);
        check_result("bp_next", 1'b0, 4'd2, 16'h7777, 16'h8888, 16'h9999);
        ack_result(16'h7777);

        // Reset during ITER cycle 3 aborts without a result.
        start_scene(16'h1234, 1'b0);
        iter_cyc(0, 0, 0, 16'h1010, 16'h2020, 16'h3030);
        iter_cyc(0, 0, 0, 16'h1010, 16'h2020, 16'h3030);
        rst = 1'b1;
        tick();
        check("rst_mid_busy", bus.o_busy, 1'b0);
        check("rst_mid_rv", bus.o_result_valid, 1'b0);
        check("rst_mid_scene", bus.o_scene, 16'h0);
        check("rst_mid_count", bus.o_iter_count, 4'd0);
        check("rst_mid_color", bus.o_color, 16'h0);
        rst = 1'b0;
        set_conv(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_mid_no_result", bus.o_result_valid, 1'b0);
            check("rst_mid_idle", bus.o_scene_ready, 1'b1);
        end
        start_scene(16'h5A5A, 1'b0);
        iter_cyc(1, 1, 1, 16'hABCD, 16'hBCDE, 16'hCDEF);
        iter_cyc(1, 1, 1, 16'hABCD, 16'hBCDE, 16'hCDEF);
        check_result("after_rst", 1'b0, 4'd2, 16'hABCD, 16'hBCDE, 16'hCDEF);
        ack_result(16'hABCD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
